// File: rtl/ysyx_25040129_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_lsu
//
// Load/store and writeback stage of the single-issue ysyx_25040129 core.
// Takes one executed instruction at a time. It performs at most one memory
// access over a valid/ready request and valid response bus, then formats load
// data and presents a single-cycle register-file write.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   in_valid/ready    instruction handshake from execute (ready only in IDLE)
//   in_is_load/store  memory op type (both low = ALU-only, both high = store)
//   in_funct3         RISC-V size/sign field
//   in_addr           effective address, or ALU result for ALU-only ops
//   in_wdata          store data (rs2)
//   in_rd             destination register index
//   in_reg_write      instruction writes rd
//   mem_req_*         request channel: valid/ready, wen, word address,
//                     lane-replicated wdata, byte mask
//   mem_rsp_valid     response/ack for the outstanding request
//   mem_rdata         read word
//   rd/reg_write/result register-file write port, live only in writeback
//   done              one-cycle retire pulse, coincident with writeback
//   err               with done: misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module ysyx_25040129_lsu #(
    parameter int REGS_DIG = 5
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_load,
    input  logic                in_is_store,
    input  logic [2:0]          in_funct3,
    input  logic [31:0]         in_addr,
    input  logic [31:0]         in_wdata,
    input  logic [REGS_DIG-1:0] in_rd,
    input  logic                in_reg_write,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rdata,

    output logic [REGS_DIG-1:0] rd,
    output logic                reg_write,
    output logic [31:0]         result,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Loads reject 011/110/111. Stores only know b/h/w (000/001/010).
    function automatic logic funct3_illegal(input logic       is_store,
                                            input logic [2:0] f3);
        logic bad;
        if (is_store) begin
            bad = f3[2] | (f3[1:0] == 2'b11);
        end else begin
            bad = (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
        end
        return bad;
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0, bytes are always fine.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                              input logic [1:0] lane);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = 4'b0011 << lane;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicating the datum across lanes lets memory pick it up with the
    // byte mask alone, without shifting.
    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = 32'(b);
            3'b100:  r = {24'h0, b};
            3'b001:  r = 32'(h);
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Accept-time decode of the incoming instruction
    // -----------------------------------------------------------------------
    logic        op_mem_d;
    logic        op_store_d;
    logic        acc_err_d;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;

    always_comb begin
        op_store_d = in_is_store;
        op_mem_d   = in_is_load | in_is_store;
        acc_err_d  = op_mem_d & (funct3_illegal(op_store_d, in_funct3) |
                                 misaligned(in_funct3, in_addr[1:0]));
        wmask_d    = op_store_d ? store_mask(in_funct3, in_addr[1:0]) : 4'h0;
        wdata_d    = op_store_d ? store_data(in_funct3, in_wdata) : 32'h0;
    end

    // -----------------------------------------------------------------------
    // State, latched instruction fields and registered outputs
    // -----------------------------------------------------------------------
    state_t              state_q;
    logic                in_ready_q;
    logic                mem_req_valid_q;
    logic                mem_wen_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_wmask_q;
    logic [REGS_DIG-1:0] rd_q;
    logic                reg_write_q;
    logic [31:0]         result_q;
    logic                done_q;
    logic                err_q;

    // Fields held across REQ/WAIT for the deferred writeback.
    logic [2:0]          funct3_q;
    logic [1:0]          lane_q;
    logic                is_store_q;
    logic [REGS_DIG-1:0] rd_lat_q;
    logic                rw_lat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Dropping to IDLE abandons any in-flight request; a late
            // response then arrives outside WAIT and is ignored.
            state_q         <= S_IDLE;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wdata_q     <= 32'h0;
            mem_wmask_q     <= 4'h0;
            rd_q            <= '0;
            reg_write_q     <= 1'b0;
            result_q        <= 32'h0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        funct3_q   <= in_funct3;
                        lane_q     <= in_addr[1:0];
                        is_store_q <= op_store_d;
                        rd_lat_q   <= in_rd;
                        rw_lat_q   <= in_reg_write & ~op_store_d;
                        if (!op_mem_d || acc_err_d) begin
                            // ALU-only or rejected access: straight to
                            // writeback, no bus traffic.
                            state_q     <= S_WB;
                            done_q      <= 1'b1;
                            err_q       <= acc_err_d;
                            rd_q        <= in_rd;
                            reg_write_q <= in_reg_write & ~op_store_d & ~acc_err_d;
                            result_q    <= op_mem_d ? 32'h0 : in_addr;
                        end else begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_wen_q       <= op_store_d;
                            mem_addr_q      <= {in_addr[31:2], 2'b00};
                            mem_wdata_q     <= wdata_d;
                            mem_wmask_q     <= wmask_d;
                        end
                    end
                end

                S_REQ: begin
                    // Request fields stay put until ready; a response
                    // seen in this cycle is not consumed.
                    if (mem_req_ready) begin
                        state_q         <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                        mem_wen_q       <= 1'b0;
                        mem_addr_q      <= 32'h0;
                        mem_wdata_q     <= 32'h0;
                        mem_wmask_q     <= 4'h0;
                    end
                end

                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_q     <= S_WB;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                        rd_q        <= rd_lat_q;
                        reg_write_q <= rw_lat_q;
                        result_q    <= is_store_q ? 32'h0
                                                  : load_extract(funct3_q, lane_q, mem_rdata);
                    end
                end

                S_WB: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    rd_q        <= '0;
                    reg_write_q <= 1'b0;
                    result_q    <= 32'h0;
                end

                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_wen       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign rd            = rd_q;
    assign reg_write     = reg_write_q;
    assign result        = result_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
module tb_ysyx_25040129_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] result;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    ysyx_25040129_lsu #(.REGS_DIG(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .rd(rd), .reg_write(reg_write), .result(result),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic [31:0] res;
    } wb_t;

    wb_t exp_q[$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int req_lo_cnt = 0;
    bit mon_en = 0;

    // responder configuration, written by the stimulus after each accept
    int          rdly = 0;
    int          sdly = 0;
    bit          rsp_en = 1;
    logic [31:0] rsp_word = 32'h0;
    logic [31:0] cap_addr;
    logic        cap_wen;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wmask;

    logic rsp_r;
    logic stray_r;
    int   stray_req = 0;
    int   stray_done = 0;
    assign mem_rsp_valid = rsp_r | stray_r;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> {a[1:0], 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // Scoreboard monitor: pops one expectation per retire pulse.
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done === 1'b1) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wb_unexpected rd=%0d result=%h required=no writeback", rd, result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_rd_rw_err_result", 72'({rd, reg_write, err, result}),
                            72'({e.rd, e.rw, e.err, e.res}));
                    end
                end else begin
                    chk("idle_wb_port_zero", 72'({rd, reg_write, err, result}), 72'(0));
                end
            end
        end
    end

    // Bus activity counters sampled at the DUT's own edge.
    always @(posedge clk) begin
        if (mem_req_valid === 1'b1) begin
            req_cnt <= req_cnt + 1;
            if (mem_req_ready === 1'b0) req_lo_cnt <= req_lo_cnt + 1;
        end
    end

    // Memory responder: ready after rdly cycles, response sdly cycles later.
    initial begin : responder
        mem_req_ready = 1'b0;
        rsp_r = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) begin
                cap_addr  = mem_addr;
                cap_wen   = mem_wen;
                cap_wdata = mem_wdata;
                cap_wmask = mem_wmask;
                for (int k = 0; k < rdly; k++) begin
                    @(negedge clk);
                    chk("req_held_stable", 72'({mem_req_valid, mem_wen, mem_wmask, mem_addr}),
                        72'({1'b1, cap_wen, cap_wmask, cap_addr}));
                    chk("req_wdata_stable", 72'(mem_wdata), 72'(cap_wdata));
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (rsp_en) begin
                    for (int k = 0; k < sdly; k++) @(negedge clk);
                    rsp_r = 1'b1;
                    mem_rdata = rsp_word;
                    @(negedge clk);
                    rsp_r = 1'b0;
                    mem_rdata = 32'h0;
                end
            end
        end
    end

    initial begin : stray
        stray_r = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_r = 1'b1;
                stray_done++;
                @(negedge clk);
                stray_r = 1'b0;
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] r, input logic rw,
                         input int rd_dly, input int rs_dly,
                         input logic [31:0] word, input bit ren);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_is_load = ld;
        in_is_store = st;
        in_funct3 = f3;
        in_addr = a;
        in_wdata = wd;
        in_rd = r;
        in_reg_write = rw;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rdly = rd_dly;
            sdly = rs_dly;
            rsp_word = word;
            rsp_en = ren;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wb_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic push(input logic [4:0] r, input logic rw, input logic e, input logic [31:0] res);
        wb_t w;
        w.rd = r; w.rw = rw; w.err = e; w.res = res;
        exp_q.push_back(w);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rc0, lo0, dc0;
        logic [2:0]  f3;
        logic [1:0]  lane;
        logic [31:0] a, w;
        logic [2:0]  f3tab [5];
        f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b010;
        f3tab[3] = 3'b100; f3tab[4] = 3'b101;

        rst = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'b0; in_addr = 32'h0; in_wdata = 32'h0;
        in_rd = 5'd0; in_reg_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_bus", 72'({in_ready, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata}),
            72'({1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}));
        chk("reset_wb", 72'({rd, reg_write, result, done, err}), 72'(0));
        rst = 1'b1;
        mon_en = 1'b1;

        // ALU-only op
        push(5'd5, 1'b1, 1'b0, 32'h1234);
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b1);
        @(negedge clk);
        chk("alu_done_next_cycle", 72'({done, in_ready}), 72'({1'b1, 1'b0}));
        @(negedge clk);
        chk("alu_ready_back", 72'(in_ready), 72'(1));
        wait_idle();

        // lb sign extension, lbu, lh, lhu, lw
        push(5'd3, 1'b1, 1'b0, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd3, 1'b1, 2, 2, 32'h80FF_7F01, 1'b1);
        wait_idle();
        chk("lb_bus", 72'({cap_wen, cap_wmask, cap_addr}), 72'({1'b0, 4'h0, 32'h8000_0000}));
        push(5'd4, 1'b1, 1'b0, 32'h0000_007F);
        issue(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0, 5'd4, 1'b1, 2, 2, 32'h80FF_7F01, 1'b1);
        wait_idle();
        push(5'd6, 1'b1, 1'b0, 32'hFFFF_80FF);
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd6, 1'b1, 0, 0, 32'h80FF_7F01, 1'b1);
        wait_idle();
        push(5'd6, 1'b1, 1'b0, 32'h0000_7F01);
        issue(1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0, 5'd6, 1'b1, 1, 0, 32'h80FF_7F01, 1'b1);
        wait_idle();
        push(5'd8, 1'b1, 1'b0, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd8, 1'b1, 0, 1, 32'hCAFE_F00D, 1'b1);
        wait_idle();

        // sh with request held for 3 cycles of ready low
        push(5'd7, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hAABB_CCDD, 5'd7, 1'b1, 3, 1, 32'h0, 1'b1);
        lo0 = req_lo_cnt;
        wait_idle();
        chk("sh_bus", 72'({cap_wen, cap_wmask, cap_addr}), 72'({1'b1, 4'b1100, 32'h8000_0000}));
        chk("sh_wdata", 72'(cap_wdata), 72'(32'hCCDD_CCDD));
        chk("sh_held_cycles", 72'(req_lo_cnt - lo0), 72'(3));

        // sb and store-with-both-flags (treated as sw)
        push(5'd1, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_5678, 5'd1, 1'b1, 0, 0, 32'h0, 1'b1);
        wait_idle();
        chk("sb_bus", 72'({cap_wen, cap_wmask, cap_wdata}), 72'({1'b1, 4'b0010, 32'h7878_7878}));
        push(5'd2, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 5'd2, 1'b1, 1, 1, 32'h5555_5555, 1'b1);
        wait_idle();
        chk("ldst_as_sw", 72'({cap_wen, cap_wmask, cap_wdata}), 72'({1'b1, 4'b1111, 32'hDEAD_BEEF}));

        // misaligned lw and illegal funct3: no bus request, err next cycle
        rc0 = req_cnt;
        push(5'd9, 1'b0, 1'b1, 32'h0);
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b1);
        @(negedge clk);
        chk("misaligned_err_next", 72'({done, err, reg_write}), 72'({1'b1, 1'b1, 1'b0}));
        wait_idle();
        push(5'd10, 1'b0, 1'b1, 32'h0);
        issue(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0, 5'd10, 1'b1, 0, 0, 32'h0, 1'b1);
        wait_idle();
        push(5'd11, 1'b0, 1'b1, 32'h0);
        issue(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd11, 1'b1, 0, 0, 32'h0, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("err_no_request", 72'(req_cnt - rc0), 72'(0));

        // reset while waiting for a response, then a stray response
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd4, 1'b1, 0, 0, 32'h1111_1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_wait_bus", 72'({in_ready, mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata}),
            72'({1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}));
        chk("rst_wait_wb", 72'({rd, reg_write, result, done, err}), 72'(0));
        dc0 = done_cnt;
        stray_req++;
        repeat (6) @(negedge clk);
        chk("rst_no_writeback", 72'(done_cnt - dc0), 72'(0));
        chk("rst_still_idle", 72'(in_ready), 72'(1));

        // back-to-back loads under random stalls
        dc0 = done_cnt;
        for (int i = 0; i < 100; i++) begin
            f3 = f3tab[$urandom_range(0, 4)];
            lane = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) lane[0] = 1'b0;
            else if (f3[1:0] == 2'b10) lane = 2'b00;
            a = 32'h8000_0000 | {16'h0, 14'($urandom_range(0, 16383)), lane};
            w = $urandom;
            push(5'(i % 32), 1'b1, 1'b0, model_load(f3, a, w));
            issue(1'b1, 1'b0, f3, a, 32'h0, 5'(i % 32), 1'b1,
                  $urandom_range(0, 5), $urandom_range(0, 5), w, 1'b1);
        end
        wait_idle();
        chk("random_done_count", 72'(done_cnt - dc0), 72'(100));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
